fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
//  Single-clock FIFO with integrated storage and configurable depth, width and read mode.
//  Provides full/empty, programmable almost-full/almost-empty, occupancy count and sticky
//  overflow/underflow error flags. Serves as the same-clock counterpart of the dual-clock FIFO.
//  Used wherever producer and consumer share I_CLK.
// PARAMETERS
//  DW      8   data width in bits
//  AW      4   address width; depth = 2**AW words
//  AF_LVL  12  O_ALMOST_FULL asserted when count >= AF_LVL (legal 1..2**AW)
//  AE_LVL  4   O_ALMOST_EMPTY asserted when count <= AE_LVL (legal 0..2**AW-1)
//  FWFT    0   0 = standard registered read, 1 = first-word-fall-through
// PORTS
//  I_CLK           in   1     clock; all logic on rising edge
//  I_RST_N         in   1     synchronous active-low reset
//  I_WR_EN         in   1     write request
//  I_WR_DATA       in   DW    write data
//  I_RD_EN         in   1     read/pop request
//  O_RD_DATA       out  DW    read data
//  O_RD_VALID      out  1     O_RD_DATA holds a valid word
//  O_FULL          out  1     count == 2**AW
//  O_EMPTY         out  1     count == 0
//  O_ALMOST_FULL   out  1     count >= AF_LVL
//  O_ALMOST_EMPTY  out  1     count <= AE_LVL
//  O_COUNT         out  AW+1  words stored, 0..2**AW
//  I_CLR_ERR       in   1     clears O_OVF/O_UDF
//  O_OVF           out  1     sticky: write attempted while full
//  O_UDF           out  1     sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (I_RST_N low at edge): wr/rd pointers, count, O_RD_DATA, O_RD_VALID, O_OVF,
//    O_UDF all 0. O_EMPTY=1, O_ALMOST_EMPTY=1, O_FULL=0, O_ALMOST_FULL=0. Storage not reset.
//    Reset overrides every other input in that cycle, including mid-burst.
//  - Pointers: AW+1-bit binary. Low AW bits address storage; MSB is the wrap bit.
//    Full  = MSBs differ and low bits equal. Empty = pointers equal.
//  - Write is accepted iff I_WR_EN && !O_FULL: stores at the wr address; wr_ptr+1.
//  - Read is accepted iff I_RD_EN && !O_EMPTY: rd_ptr+1.
//  - Flag gating uses the registered state only. At full, a simultaneous rd+wr accepts the
//    read only; the write is rejected and sets O_OVF. At empty, a simultaneous rd+wr accepts
//    the write only; the read is rejected and sets O_UDF.
//  - Count register update: +1 on write only, -1 on read only, unchanged on both or neither.
//    All flags decode from the registered count, so they are valid the cycle after the edge.
//  - FWFT=0:
//    - An accepted read registers mem[rd_addr] into O_RD_DATA.
//    - O_RD_VALID=1 in the following cycle, otherwise 0. Latency is 1 clock.
//    - O_RD_DATA holds its value when there is no read.
//  - FWFT=1:
//    - O_RD_DATA = mem[rd_addr] (combinational from storage). O_RD_VALID = !O_EMPTY.
//    - I_RD_EN acts as pop/ack.
//    - A word written into an empty FIFO is visible the cycle after the write.
//    - O_RD_DATA is don't-care while O_EMPTY=1.
//  - Wrap-around: pointers roll naturally modulo 2**(AW+1). No special case is needed.
//  - Error flags: set on an offending request, held until I_CLR_ERR. If set and clear occur
//    in the same cycle, set wins. Rejected requests never move pointers or count.
//  - Elaboration must fail (error) if AF_LVL or AE_LVL is out of its legal range.
// TESTING
//  1 fill: reset, 16 writes 0x00..0x0F (defaults) -> COUNT 1..16; ALMOST_FULL at count 12;
//    FULL at 16; 17th write -> OVF=1, COUNT stays 16.
//  2 drain (FWFT=0): 16 reads -> data 0x00..0x0F, each 1 clk after I_RD_EN with RD_VALID=1;
//    EMPTY at end; 17th read -> UDF=1, RD_VALID=0.
//  3 simultaneous: at COUNT=5, rd+wr for 10 cycles -> COUNT stays 5, data in order.
//    At full: rd+wr -> COUNT 15, OVF=1. At empty: rd+wr -> COUNT 1, UDF=1.
//  4 wrap: 3 rounds of write 10 / read 10 (pointers cross 16 and 32) -> data order intact,
//    COUNT and flags correct at every step.
//  5 reset mid-op: I_RST_N low at COUNT=9 with OVF=1 and rd/wr active -> next cycle
//    COUNT=0, EMPTY=1, OVF=0, RD_VALID=0.
//  6 FWFT=1: write 0xA5 into empty FIFO -> next cycle RD_VALID=1, RD_DATA=0xA5 without
//    I_RD_EN. Pop -> EMPTY=1. I_CLR_ERR clears OVF/UDF.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Purpose : single-clock FIFO with storage, full/empty, almost flags, count and sticky error flags.
// Latency : FWFT=0 read data valid 1 clk after accepted I_RD_EN; FWFT=1 head word visible 1 clk after write.
// Backpr. : writes refused while O_FULL (sets O_OVF), reads refused while O_EMPTY (sets O_UDF).
//
// Ports:
//   I_CLK, I_RST_N        clock and synchronous active-low reset
//   I_WR_EN, I_WR_DATA    write request and data
//   I_RD_EN               read request (pop/ack in FWFT mode)
//   O_RD_DATA, O_RD_VALID read data and its qualifier
//   O_FULL, O_EMPTY       occupancy extremes
//   O_ALMOST_FULL/EMPTY   count >= AF_LVL / count <= AE_LVL
//   O_COUNT               words stored, 0..2**AW
//   I_CLR_ERR             clears the sticky error flags
//   O_OVF, O_UDF          sticky overflow / underflow
module fifo_sync_flags #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_WR_EN,
    input  logic [DW-1:0] I_WR_DATA,
    input  logic          I_RD_EN,
    output logic [DW-1:0] O_RD_DATA,
    output logic          O_RD_VALID,
    output logic          O_FULL,
    output logic          O_EMPTY,
    output logic          O_ALMOST_FULL,
    output logic          O_ALMOST_EMPTY,
    output logic [AW:0]   O_COUNT,
    input  logic          I_CLR_ERR,
    output logic          O_OVF,
    output logic          O_UDF
);

    localparam int DEPTH = 1 << AW;

    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
        $error("fifo_sync_flags: AF_LVL out of range 1..2**AW");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_flags: AE_LVL out of range 0..2**AW-1");
    end

    localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;

    // Wrap bit differs with equal low bits means a whole lap ahead.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    // Gating uses registered flags only, so at full a rd+wr pops without pushing
    // and at empty a rd+wr pushes without popping.
    assign wr_acc = I_WR_EN && !full;
    assign rd_acc = I_RD_EN && !empty;

    // Storage has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge I_CLK) begin
        if (I_RST_N && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= I_WR_DATA;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over a same-cycle clear.
            ovf <= (I_WR_EN && full)  || (ovf && !I_CLR_ERR);
            udf <= (I_RD_EN && empty) || (udf && !I_CLR_ERR);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign O_RD_DATA  = mem[rd_ptr[AW-1:0]];
        assign O_RD_VALID = !empty;
    end else begin : g_std
        logic [DW-1:0] rd_data_q;
        logic          rd_valid_q;

        always_ff @(posedge I_CLK) begin
            if (!I_RST_N) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
                rd_valid_q <= rd_acc;
            end
        end

        assign O_RD_DATA  = rd_data_q;
        assign O_RD_VALID = rd_valid_q;
    end

    assign O_FULL         = full;
    assign O_EMPTY        = empty;
    assign O_ALMOST_FULL  = (count >= AF_C);
    assign O_ALMOST_EMPTY = (count <= AE_C);
    assign O_COUNT        = count;
    assign O_OVF          = ovf;
    assign O_UDF          = udf;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Purpose : exercises fifo_sync_flags in standard (FWFT=0) and fall-through (FWFT=1) modes.
// Latency : inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpr. : n/a (bench drives the FIFO directly).
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-read instance
    logic       rst_n, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    // Fall-through instance
    logic       f_rst_n, f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_wr_data;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] f_count;

    fifo_sync_flags #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .FWFT(0)) dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_WR_EN(wr_en), .I_WR_DATA(wr_data),
        .I_RD_EN(rd_en), .O_RD_DATA(rd_data), .O_RD_VALID(rd_valid),
        .O_FULL(full), .O_EMPTY(empty), .O_ALMOST_FULL(afull), .O_ALMOST_EMPTY(aempty),
        .O_COUNT(count), .I_CLR_ERR(clr_err), .O_OVF(ovf), .O_UDF(udf)
    );

    fifo_sync_flags #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .FWFT(1)) dut_fwft (
        .I_CLK(clk), .I_RST_N(f_rst_n), .I_WR_EN(f_wr_en), .I_WR_DATA(f_wr_data),
        .I_RD_EN(f_rd_en), .O_RD_DATA(f_rd_data), .O_RD_VALID(f_rd_valid),
        .O_FULL(f_full), .O_EMPTY(f_empty), .O_ALMOST_FULL(f_afull), .O_ALMOST_EMPTY(f_aempty),
        .O_COUNT(f_count), .I_CLR_ERR(f_clr_err), .O_OVF(f_ovf), .O_UDF(f_udf)
    );

    int tests = 0;
    int fails = 0;

    // Reference state for the standard instance
    logic [7:0] sb[$];
    int         m_count = 0;
    bit         m_ovf   = 0;
    bit         m_udf   = 0;
    bit         m_valid = 0;
    logic [7:0] m_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock on the standard instance: drive, update reference, clock, compare all outputs.
    task automatic step(input bit w, input bit r, input logic [7:0] d,
                        input bit clr = 1'b0, input bit rst = 1'b1);
        bit m_full, m_empty, wa, ra;
        wr_en = w; rd_en = r; wr_data = d; clr_err = clr; rst_n = rst;
        m_full  = (m_count == 16);
        m_empty = (m_count == 0);
        wa = w && !m_full;
        ra = r && !m_empty;
        if (!rst) begin
            sb.delete();
            m_count = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_data = 8'h00;
        end else begin
            if (ra) begin
                if (sb.size() == 0) m_data = 8'hxx;
                else m_data = sb.pop_front();
            end
            if (wa) sb.push_back(d);
            m_valid = ra;
            m_count = m_count + (wa ? 1 : 0) - (ra ? 1 : 0);
            m_ovf = (w && m_full)  || (m_ovf && !clr);
            m_udf = (r && m_empty) || (m_udf && !clr);
        end
        @(posedge clk); #1;
        chk("count",     32'(count),    32'(m_count));
        chk("full",      32'(full),     32'(m_count == 16));
        chk("empty",     32'(empty),    32'(m_count == 0));
        chk("alm_full",  32'(afull),    32'(m_count >= 12));
        chk("alm_empty", 32'(aempty),   32'(m_count <= 4));
        chk("ovf",       32'(ovf),      32'(m_ovf));
        chk("udf",       32'(udf),      32'(m_udf));
        chk("rd_valid",  32'(rd_valid), 32'(m_valid));
        chk("rd_data",   32'(rd_data),  32'(m_data));
    endtask

    task automatic ftick;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
        f_rst_n = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00; f_clr_err = 1'b0;
        #1;

        // Reset state
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("rst_empty_const", 32'(empty), 32'd1);
        chk("rst_aempty_const", 32'(aempty), 32'd1);

        // 1: fill 0x00..0x0F, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        step(1, 0, 8'hEE);
        chk("fill_ovf_const", 32'(ovf), 32'd1);
        chk("fill_cnt16_const", 32'(count), 32'd16);

        // 2: drain, each word one clock after its read
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00);
            chk("drain_data", 32'(rd_data), 32'(i));
        end
        step(0, 1, 8'h00);
        chk("drain_udf_const", 32'(udf), 32'd1);
        chk("drain_vld_const", 32'(rd_valid), 32'd0);
        step(0, 1, 8'h00, 1);   // set beats clear
        chk("set_wins_udf", 32'(udf), 32'd1);
        step(0, 0, 8'h00, 1);

        // 3: simultaneous read+write at 5, at full, at empty
        for (int i = 0; i < 5; i++) step(1, 0, 8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 8'h30 + 8'(i));
            chk("simul_cnt5", 32'(count), 32'd5);
        end
        for (int i = 0; i < 11; i++) step(1, 0, 8'h40 + 8'(i));
        step(1, 1, 8'h55);
        chk("full_rw_cnt", 32'(count), 32'd15);
        chk("full_rw_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00);
        step(1, 1, 8'h77);
        chk("empty_rw_cnt", 32'(count), 32'd1);
        chk("empty_rw_udf", 32'(udf), 32'd1);
        step(0, 1, 8'h00, 1);
        chk("clr_ovf", 32'(ovf), 32'd0);

        // 4: wrap-around, 3 rounds of 10 in / 10 out
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 8'h80 + 8'(k * 16 + i));
            for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
        end

        // 5: reset mid-operation with OVF set and count 9
        for (int i = 0; i < 17; i++) step(1, 0, 8'hC0 + 8'(i));
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00);
        chk("pre_rst_cnt9", 32'(count), 32'd9);
        step(1, 1, 8'hDD, 0, 0);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_vld", 32'(rd_valid), 32'd0);
        step(0, 0, 8'h00);

        // 6: first-word-fall-through instance
        f_rst_n = 1'b1;
        ftick();
        chk("f_rst_empty", 32'(f_empty), 32'd1);
        chk("f_rst_vld", 32'(f_rd_valid), 32'd0);
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        ftick();
        f_wr_en = 1'b0;
        chk("f_vld", 32'(f_rd_valid), 32'd1);
        chk("f_data", 32'(f_rd_data), 32'hA5);
        chk("f_cnt1", 32'(f_count), 32'd1);
        ftick();
        chk("f_hold_data", 32'(f_rd_data), 32'hA5);
        f_rd_en = 1'b1;
        ftick();
        chk("f_pop_empty", 32'(f_empty), 32'd1);
        chk("f_pop_vld", 32'(f_rd_valid), 32'd0);
        ftick();
        f_rd_en = 1'b0;
        chk("f_udf", 32'(f_udf), 32'd1);
        for (int i = 0; i < 17; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'h10 + 8'(i);
            ftick();
        end
        f_wr_en = 1'b0;
        chk("f_full", 32'(f_full), 32'd1);
        chk("f_ovf", 32'(f_ovf), 32'd1);
        chk("f_head", 32'(f_rd_data), 32'h10);
        f_rd_en = 1'b1;
        ftick();
        f_rd_en = 1'b0;
        chk("f_head2", 32'(f_rd_data), 32'h11);
        chk("f_cnt15", 32'(f_count), 32'd15);
        f_clr_err = 1'b1;
        ftick();
        f_clr_err = 1'b0;
        chk("f_clr_ovf", 32'(f_ovf), 32'd0);
        chk("f_clr_udf", 32'(f_udf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
